// File: rtl/pcm_out_pkg.sv
// ---------------------------------------------------------------------------
// pcm_out_pkg
// Shared types and constants for the PCM-to-I2S output stage.
//   state_t       : serializer FSM state (IDLE, PRIME, RUN)
//   FRAME_BITS    : BCLK periods per stereo frame
//   SAMPLE_W      : PCM sample width
//   BIT_CNT_W     : width of the in-frame bit counter
//   lrck_for_bit  : word-select level for a given in-frame bit position
// Build option: define I2S_LJ_EN for left-justified framing; default is
// standard (Philips) I2S with LRCK leading the MSB by one bit clock.
// ---------------------------------------------------------------------------
package pcm_out_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int FRAME_BITS = 32;
    localparam int SAMPLE_W   = 16;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    // Bit 0 carries the left MSB, bit 16 the right MSB.
    function automatic logic lrck_for_bit(input logic [BIT_CNT_W-1:0] bit_cnt);
`ifdef I2S_LJ_EN
        // Left-justified: word select changes together with the MSB.
        return (bit_cnt >= 5'd16);
`else
        // Standard I2S: word select changes one bit clock before the MSB.
        return (bit_cnt >= 5'd15) && (bit_cnt <= 5'd30);
`endif
    endfunction

endpackage

// File: rtl/pcm_sync_fifo.sv
// ---------------------------------------------------------------------------
// pcm_sync_fifo
// Single-clock FIFO with a two-entry read port. The consumer always removes
// samples in L/R pairs, so the two oldest entries are presented together and
// i_pop2 retires both at once. The caller must only pop when o_count >= 2.
// Ports:
//   Clk, Rst   : clock, synchronous active-high reset (empties the FIFO)
//   i_push     : write strobe, ignored while o_full
//   i_wdata    : write data
//   i_pop2     : remove the two oldest entries
//   o_rdata0   : oldest entry
//   o_rdata1   : second-oldest entry
//   o_count    : registered occupancy, 0 .. 2^DEPTH_LOG2
//   o_full     : occupancy equals depth
// ---------------------------------------------------------------------------
module pcm_sync_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_pop2,
    output logic [WIDTH-1:0]      o_rdata0,
    output logic [WIDTH-1:0]      o_rdata1,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_push;
    logic [DEPTH_LOG2-1:0] w_rd_ptr_p1;
    logic [CNT_W-1:0]      w_pop_amt;

    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_count     = r_count;
    assign w_push      = i_push && !o_full;
    assign w_rd_ptr_p1 = r_rd_ptr + DEPTH_LOG2'(1);
    assign w_pop_amt   = i_pop2 ? CNT_W'(2) : '0;

    assign o_rdata0 = r_mem[r_rd_ptr];
    assign o_rdata1 = r_mem[w_rd_ptr_p1];

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (i_pop2) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(2);
            end
            // Push and pop may coincide; a push at depth-1 alongside a pop is legal.
            r_count <= r_count + CNT_W'(w_push) - w_pop_amt;
        end
    end

endmodule

// File: rtl/pcm_i2s_out.sv
// ---------------------------------------------------------------------------
// pcm_i2s_out
// Output stage of the MP3 decoder: buffers 16-bit PCM samples written by the
// decoder and serializes them as stereo I2S to the audio DAC.
// Ports:
//   Clk          : system clock
//   Rst          : synchronous reset, active-high
//   Enable       : serializer run enable; low forces IDLE, FIFO kept
//   Winc         : sample write strobe from decoder
//   Wdata[31:0]  : sample, only [15:0] used (two's complement)
//   Wfull        : FIFO full, decoder must hold off
//   Sclk         : I2S bit clock
//   Lrck         : I2S word select, 0 = left, 1 = right
//   Sdata        : I2S serial data, MSB first
//   Overflow     : sticky, a write was attempted while full
//   Underrun_cnt : saturating count of zero-filled frames
// Build option: I2S_LJ_EN selects left-justified framing (see pcm_out_pkg).
//
// state | meaning
// IDLE  | disabled, outputs held low, divider and bit counter cleared
// PRIME | enabled, waiting for PRIME_LEVEL samples before starting
// RUN   | bit clock running, frames loaded every 32 bit clocks
// ---------------------------------------------------------------------------
module pcm_i2s_out
    import pcm_out_pkg::*;
#(
    parameter int DEPTH_LOG2  = 6,
    parameter int BCLK_DIV    = 4,
    parameter int PRIME_LEVEL = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Enable,
    input  logic        Winc,
    input  logic [31:0] Wdata,
    output logic        Wfull,
    output logic        Sclk,
    output logic        Lrck,
    output logic        Sdata,
    output logic        Overflow,
    output logic [15:0] Underrun_cnt
);

    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DIV_W-1:0]      r_div;
    logic                  r_sclk;
    logic                  r_lrck;
    logic                  r_first;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_overflow;
    logic [15:0]           r_underrun;

    logic [SAMPLE_W-1:0]   w_rdata0;
    logic [SAMPLE_W-1:0]   w_rdata1;
    logic [CNT_W-1:0]      w_count;
    logic                  w_full;

    logic                  w_run;
    logic                  w_div_tc;
    logic                  w_fall;
    logic [BIT_CNT_W-1:0]  w_bit_nxt;
    logic                  w_load;
    logic                  w_have_pair;
    logic                  w_pop2;
    logic [FRAME_BITS-1:0] w_frame;
    logic                  w_unused_wdata_hi;

    assign w_unused_wdata_hi = ^Wdata[31:16];

    pcm_sync_fifo #(
        .WIDTH      (SAMPLE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .Clk      (Clk),
        .Rst      (Rst),
        .i_push   (Winc),
        .i_wdata  (Wdata[SAMPLE_W-1:0]),
        .i_pop2   (w_pop2),
        .o_rdata0 (w_rdata0),
        .o_rdata1 (w_rdata1),
        .o_count  (w_count),
        .o_full   (w_full)
    );

    // Enable is folded in so that dropping it clears the datapath on the
    // same edge the FSM returns to IDLE.
    assign w_run    = (r_state == RUN) && Enable;
    assign w_div_tc = (r_div == DIV_W'(BCLK_DIV - 1));
    assign w_fall   = w_run && w_div_tc && r_sclk;

    // The first falling event after entering RUN starts a frame at bit 0
    // rather than advancing from the cleared counter.
    assign w_bit_nxt   = r_first ? '0 : (r_bit_cnt + BIT_CNT_W'(1));
    assign w_load      = w_fall && (w_bit_nxt == '0);
    assign w_have_pair = (w_count >= CNT_W'(2));
    assign w_pop2      = w_load && w_have_pair;
    assign w_frame     = w_have_pair ? {w_rdata0, w_rdata1} : '0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!Enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = PRIME;
                PRIME:   if (w_count >= CNT_W'(PRIME_LEVEL)) w_state_nxt = RUN;
                RUN:     w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Bit clock divider, bit counter and frame shifter. Sdata is the MSB of
    // the shifter, so it is low whenever the shifter is cleared.
    always_ff @(posedge Clk) begin
        if (Rst || !w_run) begin
            r_div     <= '0;
            r_sclk    <= 1'b0;
            r_lrck    <= 1'b0;
            r_first   <= 1'b1;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (w_div_tc) begin
                r_div  <= '0;
                r_sclk <= ~r_sclk;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            if (w_fall) begin
                r_first   <= 1'b0;
                r_bit_cnt <= w_bit_nxt;
                r_lrck    <= lrck_for_bit(w_bit_nxt);
                if (w_load) begin
                    r_shift <= w_frame;
                end else begin
                    r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_overflow <= 1'b0;
            r_underrun <= '0;
        end else begin
            if (Winc && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_load && !w_have_pair && (r_underrun != 16'hFFFF)) begin
                r_underrun <= r_underrun + 16'd1;
            end
        end
    end

    assign Wfull        = w_full;
    assign Sclk         = r_sclk;
    assign Lrck         = r_lrck;
    assign Sdata        = r_shift[FRAME_BITS-1];
    assign Overflow     = r_overflow;
    assign Underrun_cnt = r_underrun;

endmodule

// File: doc/pcm_i2s_out.md
Name: pcm_i2s_out

Overview:
Downstream stage of the MP3 decoder core. Accepts decoded 16-bit PCM samples over the decoder's Winc/Wdata/Wfull write interface and buffers them in a synchronous FIFO. Serializes them as stereo I2S (BCLK, LRCK, SDATA) to the audio DAC. Back-pressures the decoder through Wfull and flags underrun/overflow.

Parameters:
DEPTH_LOG2, 6, FIFO depth = 2^DEPTH_LOG2 samples (64)
BCLK_DIV, 4, Clk cycles per BCLK half-period (>=1)
PRIME_LEVEL, 2, FIFO sample count needed to leave PRIME (even, >=2, <=depth)

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous reset, active-high
Enable  in  1  serializer run enable
Winc  in  1  sample write strobe from decoder
Wdata  in  32  sample; only Wdata[15:0] used, two's complement
Wfull  out  1  FIFO full; decoder must not write
Sclk  out  1  I2S bit clock
Lrck  out  1  I2S word select, 0=left, 1=right
Sdata  out  1  I2S serial data, MSB first
Overflow  out  1  sticky: Winc seen while Wfull
Underrun_cnt  out  16  saturating count of zero-filled frames

Behaviour:
- Reset (Rst=1 at Clk edge): FIFO emptied; Wfull=0, Sclk=0, Lrck=0, Sdata=0, Overflow=0, Underrun_cnt=0; state IDLE; divider and bit_cnt=0.
- Write: sample pushed when Winc && !Wfull. Winc && Wfull: write dropped, Overflow<=1 (cleared only by Rst). Wfull = (count==2^DEPTH_LOG2), driven from registered count, so it reflects a push on the next cycle.
- Samples alternate L,R starting with L after reset; pairing is positional only.
- FSM IDLE -> PRIME when Enable=1. PRIME -> RUN when count>=PRIME_LEVEL. Any state -> IDLE immediately when Enable=0: outputs forced to 0, FIFO contents kept, bit_cnt and divider cleared.
- Divider (RUN only): counter 0..BCLK_DIV-1; Sclk toggles at terminal count. BCLK period = 2*BCLK_DIV Clk cycles; frame = 32 BCLK.
- All output updates occur on Sclk falling events (1->0). Event updates bit_cnt (mod 32), Sdata, Lrck.
- Frame load: on the falling event where bit_cnt becomes 0, if count>=2 pop two samples into 32-bit shift reg {L,R}. Otherwise load zeros and Underrun_cnt<=Underrun_cnt+1, saturating at 0xFFFF. Sdata takes shift[31] at that same event; subsequent events shift left.
- Standard I2S (default): Lrck=1 for bit_cnt 15..30, else 0, i.e. Lrck leads the MSB by one BCLK. First RUN frame begins with bit_cnt=0 load at the first falling event.
- Push and frame pop in the same cycle: count <= count+1-2. The pop test uses the pre-cycle count. A push when count==depth-1 coincident with a pop is allowed.
- Pointers wrap modulo depth; count is DEPTH_LOG2+1 bits.
- Rst mid-frame: immediate full reset; partial frame abandoned.

Optional Feature:
Macro I2S_LJ_EN.
- Defined: left-justified format. Lrck=1 for bit_cnt 16..31, aligned with the right MSB; no one-bit delay.
- Undefined: standard I2S as above.
- FIFO, underrun and handshake behaviour are identical in both modes.

Decomposition:
- Package pcm_out_pkg: state enum (IDLE, PRIME, RUN), FRAME_BITS=32, SAMPLE_W=16, function computing Lrck from bit_cnt.
- One sub-module, pcm_sync_fifo: single-clock, parameterized width/depth, outputs count and full.
- Divider, FSM and shifter remain in pcm_i2s_out.

Test Plan:
- Reset: Rst=1 for 3 Clk -> Sclk=0, Lrck=0, Sdata=0, Wfull=0, Overflow=0, Underrun_cnt=0.
- Basic frame: write 0xA5A5 then 0x3C3C, Enable=1, BCLK_DIV=4 -> RUN. First frame Sdata = 1010010110100101 then 0011110000111100. Lrck high for bit_cnt 15..30. Frame length 256 Clk.
- Full/overflow: Enable=0, 64 writes -> Wfull=1 the cycle after the 64th. 65th Winc dropped, Overflow=1. Serialized data later excludes the 65th sample.
- Underrun: prime 2 samples, no more writes -> frame 2 Sdata all 0, Underrun_cnt=1; frame 3 Underrun_cnt=2.
- Simultaneous: count=2, Winc at the frame-load cycle -> count=1 next cycle, no underrun.
- Mid-frame reset: Rst at bit_cnt=10 -> all outputs 0 next cycle, count=0. After re-enable, restarts in PRIME.
